// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: multi-slot frame capture buffer between the VGA pixel
// pipeline and the PC link. A rising edge on store_req captures one
// FRAME_W x FRAME_H window, packed to PIX_W bits, into a free slot of an
// internal dual-port RAM. The last complete slot streams back to the display,
// and the host can read any slot at random.
//
// Optional feature macro: FRAME_CHECKSUM_EN (16-bit sum of each captured frame).
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   store_req                 capture switch (level): rise starts, fall aborts
//   hcount/vcount             current display position
//   hoffset/voffset           capture window origin
//   in_display, pixel_in      visible-pixel flag and 24-bit RGB pixel
//   host_rd_en/addr/slot      host random read request
//   disp_dout, disp_valid     display readout (1-cycle RAM latency)
//   host_dout, host_valid     host readout (1-cycle RAM latency)
//   state                     0 IDLE, 1 ARM, 2 WRITE, 3 READ
//   wr_slot, rd_slot          slot being captured / last complete slot
//   frame_done                1-cycle pulse when a capture completes
//   checksum                  sum of last captured frame (0 without the macro)
module frame_buf_ctrl #(
  parameter int FRAME_W   = 600,
  parameter int FRAME_H   = 400,
  parameter int PIX_W     = 8,
  parameter int NUM_SLOTS = 2,
  localparam int NPIX = FRAME_W * FRAME_H,
  localparam int AW   = $clog2(NPIX),
  localparam int SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_req,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  input  logic [10:0]      hoffset,
  input  logic [9:0]       voffset,
  input  logic             in_display,
  input  logic [23:0]      pixel_in,
  input  logic             host_rd_en,
  input  logic [AW-1:0]    host_addr,
  input  logic [SW-1:0]    host_slot,
  output logic [PIX_W-1:0] disp_dout,
  output logic             disp_valid,
  output logic [PIX_W-1:0] host_dout,
  output logic             host_valid,
  output logic [1:0]       state,
  output logic [SW-1:0]    wr_slot,
  output logic [SW-1:0]    rd_slot,
  output logic             frame_done,
  output logic [15:0]      checksum
);

  localparam int DEPTH = NPIX * NUM_SLOTS;
  localparam int DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, WRITE = 2'd2, READ = 2'd3} state_t;

  state_t           cur, nxt;
  logic             req_q, rise, fall;
  logic             frame_valid;
  logic             hit, origin;
  logic [11:0]      h_end;
  logic [10:0]      v_end;
  logic [PIX_W-1:0] pix;
  logic [AW-1:0]    wr_cnt, wr_off, rd_cnt, disp_off;
  logic [SW-1:0]    next_slot;
  logic             wr_en, last, enter_arm;
  logic             disp_active, disp_rd, host_in_range, host_ok;
  logic [DW-1:0]    wr_addr, rd_addr;
  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_q;
  // Narrow packings drop low colour bits; fold them so they count as consumed.
  logic             pix_unused;

  assign pix_unused = ^pixel_in;
  assign rise  = store_req & ~req_q;
  assign fall  = ~store_req & req_q;
  assign state = cur;

  always_comb begin
    h_end  = {1'b0, hoffset} + 12'(FRAME_W);
    v_end  = {1'b0, voffset} + 11'(FRAME_H);
    hit    = in_display && (hcount >= hoffset) && ({1'b0, hcount} < h_end) &&
             (vcount >= voffset) && ({1'b0, vcount} < v_end);
    origin = (hcount == hoffset) && (vcount == voffset);
  end

  always_comb begin
    if (PIX_W == 8)       pix = PIX_W'({pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]});
    else if (PIX_W == 16) pix = PIX_W'({pixel_in[23:19], pixel_in[15:10], pixel_in[7:3]});
    else                  pix = PIX_W'(pixel_in);
  end

  assign next_slot = (int'(rd_slot) + 1 >= NUM_SLOTS) ? '0 : rd_slot + 1'b1;

  always_comb begin
    nxt       = cur;
    wr_en     = 1'b0;
    wr_off    = wr_cnt;
    enter_arm = 1'b0;
    case (cur)
      IDLE:  if (rise) begin
               nxt       = ARM;
               enter_arm = 1'b1;
             end
      ARM:   if (fall) nxt = frame_valid ? READ : IDLE;
             else if (hit && origin) begin
               wr_en  = 1'b1;
               wr_off = '0;
               nxt    = WRITE;
             end
      WRITE: if (fall) nxt = frame_valid ? READ : IDLE;
             else if (hit) wr_en = 1'b1;
      READ:  if (rise) begin
               nxt       = ARM;
               enter_arm = 1'b1;
             end else if (fall) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    last = wr_en && (wr_off == AW'(NPIX - 1));
    if (last) nxt = READ;
  end

  // Port B is shared: a host request steals the cycle from the display stream.
  always_comb begin
    disp_active   = frame_valid && (NUM_SLOTS > 1 || cur == READ || cur == IDLE);
    disp_rd       = disp_active && hit && !host_rd_en;
    disp_off      = origin ? '0 : rd_cnt;
    host_in_range = (int'(host_addr) < NPIX) && (int'(host_slot) < NUM_SLOTS);
    wr_addr       = DW'(wr_slot) * DW'(NPIX) + DW'(wr_off);
    rd_addr       = '0;
    if (host_rd_en) begin
      if (host_in_range) rd_addr = DW'(host_slot) * DW'(NPIX) + DW'(host_addr);
    end else begin
      rd_addr = DW'(rd_slot) * DW'(NPIX) + DW'(disp_off);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= IDLE;
      req_q       <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wr_slot     <= '0;
      rd_slot     <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      disp_valid  <= 1'b0;
      host_valid  <= 1'b0;
      host_ok     <= 1'b0;
    end else begin
      cur        <= nxt;
      req_q      <= store_req;
      frame_done <= last;
      if (enter_arm) begin
        wr_slot <= frame_valid ? next_slot : '0;
        wr_cnt  <= '0;
      end else if (wr_en) begin
        wr_cnt <= wr_off + 1'b1;
      end
      if (last) begin
        rd_slot     <= wr_slot;
        frame_valid <= 1'b1;
      end
      host_valid <= host_rd_en;
      host_ok    <= host_rd_en && host_in_range;
      disp_valid <= disp_rd;
      if (disp_rd) rd_cnt <= (disp_off == AW'(NPIX - 1)) ? '0 : disp_off + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= pix;
    rd_q <= mem[rd_addr];
  end

  assign disp_dout = disp_valid ? rd_q : '0;
  assign host_dout = host_ok ? rd_q : '0;

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      checksum <= '0;
    end else begin
      if (enter_arm)  acc <= '0;
      else if (wr_en) acc <= acc + 16'(pix);
      if (last) checksum <= acc + 16'(pix);
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_buf_ctrl.sv
`timescale 1ns/1ps
module tb_frame_buf_ctrl;
  localparam int FW = 4, FH = 2, NP = FW * FH, NS = 2, HO = 2, VO = 1;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, store_req = 1'b0, in_display = 1'b0;
  logic [10:0] hcount = '0, hoffset = 11'(HO);
  logic [9:0]  vcount = '0, voffset = 10'(VO);
  logic [23:0] pixel_in = '0;
  logic        host_rd_en = 1'b0, host_slot = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [7:0]  disp_dout, host_dout;
  logic        disp_valid, host_valid, wr_slot, rd_slot, frame_done;
  logic [1:0]  state;
  logic [15:0] checksum;

  // Second instance (NPIX=6, three slots) where out-of-range host reads are representable.
  logic        host_rd_en2 = 1'b0;
  logic [2:0]  host_addr2 = '0;
  logic [1:0]  host_slot2 = '0;
  logic [7:0]  host_dout2;
  logic        host_valid2;
  logic [7:0]  oor_unused_dd;
  logic        oor_unused_dv, oor_unused_fd;
  logic [1:0]  oor_unused_st, oor_unused_ws, oor_unused_rs;
  logic [15:0] oor_unused_ck;

  frame_buf_ctrl #(.FRAME_W(FW), .FRAME_H(FH), .PIX_W(8), .NUM_SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .store_req(store_req), .hcount(hcount), .vcount(vcount),
    .hoffset(hoffset), .voffset(voffset), .in_display(in_display), .pixel_in(pixel_in),
    .host_rd_en(host_rd_en), .host_addr(host_addr), .host_slot(host_slot),
    .disp_dout(disp_dout), .disp_valid(disp_valid), .host_dout(host_dout),
    .host_valid(host_valid), .state(state), .wr_slot(wr_slot), .rd_slot(rd_slot),
    .frame_done(frame_done), .checksum(checksum));

  frame_buf_ctrl #(.FRAME_W(3), .FRAME_H(2), .PIX_W(8), .NUM_SLOTS(3)) dut_oor (
    .clk(clk), .rst(rst), .store_req(store_req), .hcount(hcount), .vcount(vcount),
    .hoffset(hoffset), .voffset(voffset), .in_display(in_display), .pixel_in(pixel_in),
    .host_rd_en(host_rd_en2), .host_addr(host_addr2), .host_slot(host_slot2),
    .disp_dout(oor_unused_dd), .disp_valid(oor_unused_dv), .host_dout(host_dout2),
    .host_valid(host_valid2), .state(oor_unused_st), .wr_slot(oor_unused_ws),
    .rd_slot(oor_unused_rs), .frame_done(oor_unused_fd), .checksum(oor_unused_ck));

  always #5 clk = ~clk;

  int total = 0, bad = 0, n_done = 0;
  bit chk_on = 1'b0;
  logic [7:0] last_disp = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack8(input logic [23:0] p);
    return {p[23:21], p[15:13], p[7:6]};
  endfunction

  function automatic logic [23:0] gpix(input int h, input int v);
    return {8'(h * 53 + v * 17), 8'(h * 29 + v * 97), 8'(h * 71 + v * 40)};
  endfunction

  // Reference model: tracks the capture protocol and the slot contents by
  // window position, and computes what every output must show next cycle.
  int         m_st = 0, m_ws = 0, m_rs = 0, m_steal = 0;
  bit         m_fv = 1'b0, m_req_q = 1'b0;
  logic [7:0] m_mem [NS][NP];
  logic [15:0] m_acc = '0, m_cks = '0;
  int         e_state = 0, e_ws = 0, e_rs = 0;
  bit         e_done = 1'b0, e_dv = 1'b0, e_hv = 1'b0;
  logic [7:0] e_dd = '0, e_hd = '0;

  task automatic m_start();
    m_st  = 1;
    m_ws  = m_fv ? (m_rs + 1) % NS : 0;
    m_acc = '0;
  endtask

  task automatic m_write(input int idx, input logic [7:0] p);
    m_mem[m_ws][idx] = p;
    m_acc = m_acc + 16'(p);
    m_st  = 2;
    if (idx == NP - 1) begin
      e_done = 1'b1;
      m_rs   = m_ws;
      m_fv   = 1'b1;
      m_st   = 3;
      m_cks  = m_acc;
    end
  endtask

  always @(posedge clk) begin
    int  hv, vv, idx;
    bit  hit_m, rise_m, fall_m, act;
    hv     = int'(hcount);
    vv     = int'(vcount);
    hit_m  = in_display && hv >= HO && hv < HO + FW && vv >= VO && vv < VO + FH;
    idx    = (vv - VO) * FW + (hv - HO);
    rise_m = store_req && !m_req_q;
    fall_m = !store_req && m_req_q;
    if (rst) begin
      m_st = 0; m_fv = 1'b0; m_rs = 0; m_ws = 0; m_req_q = 1'b0;
      m_acc = '0; m_cks = '0;
      e_done = 1'b0; e_dv = 1'b0; e_hv = 1'b0; e_dd = '0; e_hd = '0;
    end else begin
      m_req_q = store_req;
      e_done  = 1'b0;
      e_dv    = 1'b0;
      e_hv    = host_rd_en;
      e_hd    = '0;
      if (host_rd_en) e_hd = m_mem[host_slot][host_addr];
      act = m_fv && (NS > 1 || m_st == 3 || m_st == 0);
      if (hit_m && act) begin
        if (idx == 0) m_steal = 0;
        if (host_rd_en) m_steal++;
        else begin
          e_dv = 1'b1;
          e_dd = m_mem[m_rs][(idx - m_steal + NP) % NP];
        end
      end
      case (m_st)
        0: if (rise_m) m_start();
        1: if (fall_m) m_st = m_fv ? 3 : 0;
           else if (hit_m && idx == 0) m_write(idx, pack8(pixel_in));
        2: if (fall_m) m_st = m_fv ? 3 : 0;
           else if (hit_m) m_write(idx, pack8(pixel_in));
        default: if (rise_m) m_start();
                 else if (fall_m) m_st = 0;
      endcase
    end
    e_state = m_st;
    e_ws    = m_ws;
    e_rs    = m_rs;
  end

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (chk_on) begin
      cmp("state", 32'(state), 32'(e_state));
      cmp("wr_slot", 32'(wr_slot), 32'(e_ws));
      cmp("rd_slot", 32'(rd_slot), 32'(e_rs));
      cmp("frame_done", 32'(frame_done), 32'(e_done));
      cmp("checksum", 32'(checksum), CKS_EN ? 32'(m_cks) : 32'h0);
      cmp("disp_valid", 32'(disp_valid), 32'(e_dv));
      cmp("host_valid", 32'(host_valid), 32'(e_hv));
      if (e_dv) cmp("disp_dout", 32'(disp_dout), 32'(e_dd));
      if (e_hv) cmp("host_dout", 32'(host_dout), 32'(e_hd));
    end
  end

  task automatic idle_tick();
    hcount = 11'd9; vcount = 10'd0; in_display = 1'b0;
    @(negedge clk);
  endtask

  // One raster of 3 lines x 10 columns (8 visible); window covers x 2..5, y 1..2.
  task automatic frame(input logic [23:0] pix, input bit grad, input int drop_at,
                       input int host_at, input logic [2:0] haddr, input logic hslot,
                       input logic [7:0] hexp);
    for (int v = 0; v < 3; v++) begin
      for (int h = 0; h < 10; h++) begin
        int idx;
        bit win;
        win        = h >= HO && h < HO + FW && v >= VO && v < VO + FH;
        idx        = (v - VO) * FW + (h - HO);
        hcount     = 11'(h);
        vcount     = 10'(v);
        in_display = (h < 8);
        pixel_in   = grad ? gpix(h, v) : pix;
        if (win && idx == drop_at) store_req = 1'b0;
        host_rd_en = win && idx == host_at;
        host_addr  = haddr;
        host_slot  = hslot;
        @(negedge clk);
        if (host_rd_en) begin
          cmp("steal_host_valid", 32'(host_valid), 32'd1);
          cmp("steal_host_dout", 32'(host_dout), 32'(hexp));
          cmp("steal_disp_valid", 32'(disp_valid), 32'd0);
        end
        host_rd_en = 1'b0;
        if (disp_valid) last_disp = disp_dout;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle_tick();
    chk_on = 1'b1;
    idle_tick();
    idle_tick();
    cmp("rst_state", 32'(state), 32'd0);
    cmp("rst_rd_slot", 32'(rd_slot), 32'd0);
    cmp("rst_disp_valid", 32'(disp_valid), 32'd0);
    cmp("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a capture
    store_req = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int h = 0; h < 10; h++) begin
        if (!(v == 1 && h > 5)) begin
          hcount = 11'(h); vcount = 10'(v); in_display = (h < 8); pixel_in = 24'hFF00C0;
          @(negedge clk);
        end
      end
    end
    cmp("midwrite_state", 32'(state), 32'd2);
    rst = 1'b1; store_req = 1'b0;
    idle_tick();
    cmp("rst2_state", 32'(state), 32'd0);
    cmp("rst2_outputs", 32'({disp_valid, host_valid, frame_done, wr_slot, rd_slot}), 32'd0);
    cmp("rst2_data", 32'({disp_dout, host_dout, checksum}), 32'd0);
    rst = 1'b0;
    idle_tick();

    // Full capture into slot 0
    store_req = 1'b1;
    frame(24'hFF00C0, 1'b0, -1, -1, 3'd0, 1'b0, 8'h00);
    cmp("cap1_done_count", 32'(n_done), 32'd1);
    cmp("cap1_rd_slot", 32'(rd_slot), 32'd0);
    cmp("cap1_state", 32'(state), 32'd3);
    cmp("cap1_checksum", 32'(checksum), CKS_EN ? 32'h0718 : 32'h0);
    frame(24'h000000, 1'b0, -1, -1, 3'd0, 1'b0, 8'h00);
    cmp("cap1_disp", 32'(last_disp), 32'hE3);

    // Second capture into slot 1; display stays on slot 0 until done
    store_req = 1'b0;
    idle_tick();
    store_req = 1'b1;
    last_disp = '0;
    frame(24'h00FF00, 1'b0, -1, -1, 3'd0, 1'b0, 8'h00);
    cmp("cap2_disp_old", 32'(last_disp), 32'hE3);
    cmp("cap2_rd_slot", 32'(rd_slot), 32'd1);
    cmp("cap2_done_count", 32'(n_done), 32'd2);
    cmp("cap2_checksum", 32'(checksum), CKS_EN ? 32'h00E0 : 32'h0);
    frame(24'h000000, 1'b0, -1, -1, 3'd0, 1'b0, 8'h00);
    cmp("cap2_disp_new", 32'(last_disp), 32'h1C);

    // Abort after 5 writes into slot 0
    store_req = 1'b0;
    idle_tick();
    store_req = 1'b1;
    frame(24'h0000FF, 1'b0, 5, -1, 3'd0, 1'b0, 8'h00);
    cmp("abort_state", 32'(state), 32'd3);
    cmp("abort_rd_slot", 32'(rd_slot), 32'd1);
    cmp("abort_done_count", 32'(n_done), 32'd2);
    cmp("abort_checksum", 32'(checksum), CKS_EN ? 32'h00E0 : 32'h0);

    // Host read during a display hit; slot 0 offset 7 survived the abort
    frame(24'h000000, 1'b0, -1, 3, 3'd7, 1'b0, 8'hE3);

    // Out-of-range host reads return 0 with host_valid set
    host_rd_en2 = 1'b1; host_addr2 = 3'd7; host_slot2 = 2'd0;
    idle_tick();
    cmp("oor_addr_valid", 32'(host_valid2), 32'd1);
    cmp("oor_addr_dout", 32'(host_dout2), 32'd0);
    host_addr2 = 3'd1; host_slot2 = 2'd3;
    idle_tick();
    cmp("oor_slot_valid", 32'(host_valid2), 32'd1);
    cmp("oor_slot_dout", 32'(host_dout2), 32'd0);
    host_rd_en2 = 1'b0;

    // Gradient capture (READ rise re-captures into slot 0), then a stolen cycle mid-frame
    store_req = 1'b1;
    frame(24'h000000, 1'b1, -1, -1, 3'd0, 1'b0, 8'h00);
    cmp("grad_rd_slot", 32'(rd_slot), 32'd0);
    frame(24'h000000, 1'b0, -1, 2, 3'd0, 1'b1, 8'h1C);
    cmp("grad_skew_last", 32'(last_disp), 32'(pack8(gpix(4, 2))));
    idle_tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
